noc_output_port_arbiter: RTL and testbench
==========================================

Name: noc_output_port_arbiter

Overview:
- Per-output-port arbiter in the NoC router.
- Up to five input blocks (xp, xm, yp, ym, local) request one output port through their port-control request/free signals.
- The arbiter grants the port to exactly one requester with round-robin fairness.
- The grant is held for the whole packet (wormhole), and the winner index is exported to steer the output flit mux.

Parameters:
- REQUESTERS, 5, number of requesting input blocks (2..8).
- AVAILABLE_REQUESTERS, 5'b11111, per-requester enable mask; a masked requester is never granted.

Ports:
- clk  input  1  router clock
- rst  input  1  asynchronous reset, active-high
- i_request  input  REQUESTERS  per-requester port request, level, held until granted
- i_free  input  REQUESTERS  per-requester release pulse, asserted by the owner in the cycle its tail flit is accepted
- o_grant  output  REQUESTERS  one-hot grant, registered
- o_owner  output  $clog2(REQUESTERS)  index of the current owner, valid while o_busy=1
- o_busy  output  1  port currently owned

Behaviour:
- Reset (asynchronous, rst=1):
  - o_grant=0, o_owner=0, o_busy=0, FSM=IDLE.
  - Round-robin pointer last=REQUESTERS-1, so requester 0 has top priority after reset.
  - Reset mid-packet drops the grant immediately and asynchronously.
- Effective request: req_eff = i_request & AVAILABLE_REQUESTERS.
- Winner selection is combinational: first set bit of req_eff scanning last+1, last+2, … with modulo-REQUESTERS wrap.
- FSM states IDLE and GRANTED.
- IDLE:
  - If req_eff != 0 in cycle t, then in cycle t+1: o_grant=onehot(winner), o_owner=winner, o_busy=1, last=winner, FSM=GRANTED.
  - Request-to-grant latency is 1 cycle.
  - If req_eff == 0, stay in IDLE with outputs unchanged at 0.
- GRANTED:
  - Grant is held regardless of i_request; a withdrawn request does not release the port.
  - Release occurs only on i_free[o_owner]=1.
  - i_free from a non-owner is ignored.
- Release cycle:
  - If req_eff excluding the owner's bit is nonzero, the next winner is granted in the following cycle with no idle bubble. The grant switches directly owner→winner and o_busy stays 1.
  - If only the releasing owner is still requesting, it may be regranted, but only after every other requester has been scanned; with the pointer at the owner this falls out naturally.
  - Otherwise go to IDLE: o_grant=0 and o_busy=0 next cycle.
- Invariants:
  - o_grant is always one-hot or zero.
  - o_busy equals |o_grant.
  - o_owner holds its last value while idle.
- A simultaneous new request and i_free in the same cycle are both seen. The new requester takes part in the immediate re-arbitration.
- Fairness: with N continuously requesting sources, each source is granted once per N packets.

Decomposition:
- Shared package (noc_config_pkg) holds:
  - the requester index type;
  - the port enum (X_PLUS=0, X_MINUS=1, Y_PLUS=2, Y_MINUS=3, LOCAL=4);
  - the default AVAILABLE mask constant.
- One sub-module: noc_round_robin_selector.
  - Combinational rotating-priority encoder.
  - Inputs: request vector and last pointer.
  - Outputs: one-hot winner, index and any_valid.
  - Parameterised on REQUESTERS; reusable by the virtual-channel arbiter.

Test Plan:
1. Reset then i_request=5'b00100 at cycle 2 → o_grant=5'b00100, o_owner=2, o_busy=1 at cycle 3. No change until i_free[2]; then o_grant=0 the next cycle.
2. i_request=5'b11111 held, each owner pulses i_free 4 cycles after its grant → grant order 0,1,2,3,4,0 with no idle cycle between packets.
3. Owner 1 drops i_request mid-packet while 3 requests → grant stays 5'b00010 until i_free[1]. Next cycle o_grant=5'b01000.
4. Owner 0 holds the grant; i_free[3] pulses (non-owner) → no change. AVAILABLE_REQUESTERS=5'b01111 with i_request=5'b10000 → never granted, o_busy=0.
5. rst asserted asynchronously mid-packet with o_grant=5'b00001 → o_grant=0 and o_busy=0 immediately. After release, i_request=5'b00011 → requester 0 granted first.
6. Random request/free stress, 10k cycles → one-hot holds, no grant without request in IDLE, and every requester is granted within REQUESTERS packets of asserting its request.

Source files
------------

// File: rtl/noc_config_pkg.sv
// noc_config_pkg: shared NoC router types and constants
// Holds the requester index type, the port enum, the arbiter FSM states and the default enable mask.
package noc_config_pkg;
    localparam int MAX_REQUESTERS = 8;
    typedef logic [$clog2(MAX_REQUESTERS)-1:0] req_idx_t;
    typedef enum logic [2:0] {
        X_PLUS  = 3'd0,
        X_MINUS = 3'd1,
        Y_PLUS  = 3'd2,
        Y_MINUS = 3'd3,
        LOCAL   = 3'd4
    } port_e;
    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_e;
    localparam logic [MAX_REQUESTERS-1:0] DEFAULT_AVAILABLE = '1;
endpackage

// File: rtl/noc_round_robin_selector.sv
// noc_round_robin_selector: combinational rotating-priority encoder
// Ports: request (candidates), last (previous winner; scan starts at last+1),
//        grant (one-hot winner), index (winner index), any_valid (some request present).
module noc_round_robin_selector #(
    parameter int REQUESTERS = 5
) (
    input  logic [REQUESTERS-1:0]         request,
    input  logic [$clog2(REQUESTERS)-1:0] last,
    output logic [REQUESTERS-1:0]         grant,
    output logic [$clog2(REQUESTERS)-1:0] index,
    output logic                          any_valid
);
    localparam int IW = $clog2(REQUESTERS);
    // Scan from farthest to nearest so the nearest set bit after last wins.
    always_comb begin
        index     = '0;
        any_valid = 1'b0;
        for (int i = REQUESTERS; i >= 1; i--) begin
            if (request[(int'(last) + i) % REQUESTERS]) begin
                index     = IW'((int'(last) + i) % REQUESTERS);
                any_valid = 1'b1;
            end
        end
        grant = any_valid ? {{(REQUESTERS-1){1'b0}}, 1'b1} << index : '0;
    end
endmodule

// File: rtl/noc_output_port_arbiter.sv
// noc_output_port_arbiter: wormhole round-robin arbiter for one router output port
// Ports: clk, rst (async, active-high), i_request (level per requester), i_free (owner release pulse),
//        o_grant (registered one-hot), o_owner (owner index, held while idle), o_busy (port owned).
module noc_output_port_arbiter
    import noc_config_pkg::*;
#(
    parameter int                    REQUESTERS           = 5,
    parameter logic [REQUESTERS-1:0] AVAILABLE_REQUESTERS = REQUESTERS'(DEFAULT_AVAILABLE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REQUESTERS-1:0]         i_request,
    input  logic [REQUESTERS-1:0]         i_free,
    output logic [REQUESTERS-1:0]         o_grant,
    output logic [$clog2(REQUESTERS)-1:0] o_owner,
    output logic                          o_busy
);
    localparam int OW = $clog2(REQUESTERS);
    arb_state_e            state, next_state;
    logic [REQUESTERS-1:0] req_eff, sel_grant, next_grant;
    logic [OW-1:0]         last, next_last, next_owner, sel_idx;
    logic                  sel_any, take;
    assign req_eff = i_request & AVAILABLE_REQUESTERS;
    // While granted, last equals the owner, so the owner is scanned last on re-arbitration.
    noc_round_robin_selector #(.REQUESTERS(REQUESTERS)) u_sel (
        .request   (req_eff),
        .last      (last),
        .grant     (sel_grant),
        .index     (sel_idx),
        .any_valid (sel_any)
    );
    always_comb begin
        take       = (state == ARB_IDLE) || i_free[o_owner];
        next_state = take ? (sel_any ? ARB_GRANTED : ARB_IDLE) : state;
        next_grant = take ? sel_grant : o_grant;
        next_owner = (take && sel_any) ? sel_idx : o_owner;
        next_last  = (take && sel_any) ? sel_idx : last;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB_IDLE;
            o_grant <= '0;
            o_owner <= '0;
            last    <= OW'(REQUESTERS - 1);
        end else begin
            state   <= next_state;
            o_grant <= next_grant;
            o_owner <= next_owner;
            last    <= next_last;
        end
    end
    assign o_busy = (state == ARB_GRANTED);
endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// tb_noc_output_port_arbiter: directed and random checks of the output port arbiter
module tb_noc_output_port_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] i_request = '0;
    logic [4:0] i_free = '0;
    logic [4:0] o_grant;
    logic [2:0] o_owner;
    logic       o_busy;
    logic [4:0] m_request = '0;
    logic [4:0] m_grant;
    logic [2:0] m_owner;
    logic       m_busy;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    noc_output_port_arbiter #(.REQUESTERS(5)) dut (
        .clk(clk), .rst(rst), .i_request(i_request), .i_free(i_free),
        .o_grant(o_grant), .o_owner(o_owner), .o_busy(o_busy)
    );

    noc_output_port_arbiter #(.REQUESTERS(5), .AVAILABLE_REQUESTERS(5'b01111)) dut_m (
        .clk(clk), .rst(rst), .i_request(m_request), .i_free(i_free),
        .o_grant(m_grant), .o_owner(m_owner), .o_busy(m_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        i_request = '0;
        i_free    = '0;
        m_request = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        i_request = 5'b11111;
        tick();
        checks++;
        if (o_grant !== 5'b0 || o_owner !== 3'd0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_in got grant=%b owner=%0d busy=%b exp 00000/0/0", o_grant, o_owner, o_busy);
        end
        rst = 1'b0;
        i_request = '0;
        tick();
        checks++;
        if (o_grant !== 5'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got grant=%b busy=%b exp 00000/0", o_grant, o_busy);
        end
    endtask

    task automatic test_single;
        do_reset();
        i_request = 5'b00100;
        tick();
        checks++;
        if (o_grant !== 5'b00100 || o_owner !== 3'd2 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL single_grant got grant=%b owner=%0d busy=%b exp 00100/2/1", o_grant, o_owner, o_busy);
        end
        repeat (3) tick();
        i_request = '0;
        tick();
        checks++;
        if (o_grant !== 5'b00100 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL single_hold got grant=%b busy=%b exp 00100/1", o_grant, o_busy);
        end
        i_free = 5'b00100;
        tick();
        i_free = '0;
        checks++;
        if (o_grant !== 5'b0 || o_busy !== 1'b0 || o_owner !== 3'd2) begin
            failures++;
            $display("FAIL single_release got grant=%b busy=%b owner=%0d exp 00000/0/2", o_grant, o_busy, o_owner);
        end
    endtask

    task automatic test_round_robin;
        int exp_o;
        do_reset();
        i_request = 5'b11111;
        tick();
        for (int p = 0; p < 6; p++) begin
            exp_o = p % 5;
            checks++;
            if (o_grant !== (5'd1 << exp_o) || o_owner !== 3'(exp_o) || o_busy !== 1'b1) begin
                failures++;
                $display("FAIL rr_pkt%0d got grant=%b owner=%0d busy=%b exp %b/%0d/1", p, o_grant, o_owner, o_busy, 5'd1 << exp_o, exp_o);
            end
            repeat (3) tick();
            checks++;
            if (o_grant !== (5'd1 << exp_o)) begin
                failures++;
                $display("FAIL rr_hold%0d got grant=%b exp %b", p, o_grant, 5'd1 << exp_o);
            end
            i_free = 5'd1 << exp_o;
            tick();
            i_free = '0;
        end
        i_request = '0;
        i_free = o_grant;
        tick();
        i_free = '0;
    endtask

    task automatic test_withdraw;
        do_reset();
        i_request = 5'b00010;
        tick();
        i_request = 5'b01000;
        repeat (2) tick();
        checks++;
        if (o_grant !== 5'b00010 || o_owner !== 3'd1) begin
            failures++;
            $display("FAIL withdraw_hold got grant=%b owner=%0d exp 00010/1", o_grant, o_owner);
        end
        i_free = 5'b00010;
        tick();
        i_free = '0;
        checks++;
        if (o_grant !== 5'b01000 || o_owner !== 3'd3 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL withdraw_next got grant=%b owner=%0d busy=%b exp 01000/3/1", o_grant, o_owner, o_busy);
        end
    endtask

    task automatic test_non_owner_and_mask;
        do_reset();
        i_request = 5'b00001;
        m_request = 5'b10000;
        tick();
        i_free = 5'b01000;
        tick();
        i_free = '0;
        checks++;
        if (o_grant !== 5'b00001 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL nonowner_free got grant=%b busy=%b exp 00001/1", o_grant, o_busy);
        end
        repeat (3) tick();
        checks++;
        if (m_grant !== 5'b0 || m_busy !== 1'b0) begin
            failures++;
            $display("FAIL mask_block got grant=%b busy=%b exp 00000/0", m_grant, m_busy);
        end
        m_request = 5'b11000;
        tick();
        checks++;
        if (m_grant !== 5'b01000 || m_owner !== 3'd3) begin
            failures++;
            $display("FAIL mask_other got grant=%b owner=%0d exp 01000/3", m_grant, m_owner);
        end
        m_request = '0;
    endtask

    task automatic test_async_reset;
        do_reset();
        i_request = 5'b00001;
        tick();
        checks++;
        if (o_grant !== 5'b00001) begin
            failures++;
            $display("FAIL areset_pre got grant=%b exp 00001", o_grant);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (o_grant !== 5'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL areset_drop got grant=%b busy=%b exp 00000/0", o_grant, o_busy);
        end
        rst = 1'b0;
        i_request = 5'b00011;
        tick();
        checks++;
        if (o_grant !== 5'b00001 || o_owner !== 3'd0) begin
            failures++;
            $display("FAIL areset_prio got grant=%b owner=%0d exp 00001/0", o_grant, o_owner);
        end
    endtask

    task automatic test_stress;
        logic [4:0] req, free, prev_req, prev_free, prev_grant;
        logic       new_pkt;
        int         hold, j, worst;
        int         wcnt[5];
        do_reset();
        req = '0; prev_req = '0; prev_free = '0; prev_grant = '0; hold = 0;
        for (int i = 0; i < 5; i++) wcnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            checks++;
            if ((o_grant & (o_grant - 5'd1)) != 5'd0 || o_busy !== (|o_grant)) begin
                failures++;
                $display("FAIL stress_onehot cyc=%0d got grant=%b busy=%b exp onehot/busy=|grant", c, o_grant, o_busy);
            end
            if (prev_grant == 5'd0 && o_grant != 5'd0) begin
                checks++;
                if ((o_grant & prev_req) == 5'd0) begin
                    failures++;
                    $display("FAIL stress_spurious cyc=%0d got grant=%b exp subset of %b", c, o_grant, prev_req);
                end
            end
            new_pkt = (o_grant != 5'd0) && (prev_grant == 5'd0 || (prev_free & prev_grant) != 5'd0);
            if (new_pkt) begin
                worst = 0;
                for (int i = 0; i < 5; i++) begin
                    if (o_grant[i]) wcnt[i] = 0;
                    else if (req[i]) wcnt[i]++;
                    else wcnt[i] = 0;
                    if (wcnt[i] > worst) worst = wcnt[i];
                end
                checks++;
                if (worst > 4) begin
                    failures++;
                    $display("FAIL stress_fair cyc=%0d got wait=%0d exp <=4", c, worst);
                end
                hold = $urandom_range(0, 4);
                if ($urandom_range(0, 3) != 0) req &= ~o_grant;
            end
            free = '0;
            if (o_busy) begin
                if (hold == 0) free = o_grant;
                else hold--;
            end
            j = $urandom_range(0, 4);
            if ($urandom_range(0, 7) == 0 && !o_grant[j]) free[j] = 1'b1;
            for (int i = 0; i < 5; i++)
                if (!req[i] && !o_grant[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
            prev_grant = o_grant;
            prev_req   = req;
            prev_free  = free;
            i_request  = req;
            i_free     = free;
            tick();
        end
        i_request = '0;
        i_free = '0;
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_withdraw();
        test_non_owner_and_mask();
        test_async_reset();
        test_stress();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
